// File: rtl/save_slot_store.sv
// save_slot_store: snapshot store that answers the VGA screen FSM's save/load requests.
// A save code must stay stable for HOLD_CYCLES cycles before it is committed, and each
// continuous assertion commits only once. A load returns the selected snapshot one cycle later.
// Request codes: 0 = NONE, 1..NUM_SLOTS = LOC1..LOCn, anything larger = NONE.
// Optional feature macro: SAVE_OVERWRITE_PROTECT_EN. When defined, a slot that has already
// been written is never overwritten, and the attempt pulses save_reject instead of save_done.
// Ports:
//   iVGA_CLK, iRST_n        clock, asynchronous active-low reset
//   save_signal             save request code, held for the whole request
//   sensor_input_to_save    snapshot data, sampled in the commit cycle
//   load_signal             load request code
//   sensor_output           loaded snapshot, or 0 when no valid slot is selected
//   load_valid              sensor_output carries stored data
//   slot_valid              bit k-1 is set once slot k has been written
//   save_done               one-cycle pulse for each commit
//   busy                    high while a save is qualifying, committing or armed
//   save_reject             one-cycle pulse for a blocked overwrite (0 without the feature)
module save_slot_store #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_SLOTS   = 3,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                 iVGA_CLK,
   input  logic                 iRST_n,
   input  logic [DATA_W-1:0]    save_signal,
   input  logic [DATA_W-1:0]    sensor_input_to_save,
   input  logic [DATA_W-1:0]    load_signal,
   output logic [DATA_W-1:0]    sensor_output,
   output logic                 load_valid,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic                 save_done,
   output logic                 busy,
   output logic                 save_reject
);

   localparam int unsigned CODE_W = $clog2(NUM_SLOTS + 1);
   localparam int unsigned CNT_W  = 8;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_QUAL   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_ARMED  = 2'd3;

   logic [1:0]        state, state_n;
   logic [CODE_W-1:0] cur_code, cur_code_n;
   logic [CNT_W-1:0]  hold_cnt, hold_cnt_n;
   logic              save_done_n;
   logic              busy_n;

   logic [DATA_W-1:0] slot_mem [NUM_SLOTS];

   // Request decode; out-of-range codes fold to NONE before truncation
   logic              save_ok_c, load_ok_c;
   logic [CODE_W-1:0] save_code_c, load_code_c;

   assign save_ok_c   = (save_signal != '0) && (save_signal <= DATA_W'(NUM_SLOTS));
   assign load_ok_c   = (load_signal != '0) && (load_signal <= DATA_W'(NUM_SLOTS));
   assign save_code_c = CODE_W'(save_signal);
   assign load_code_c = CODE_W'(load_signal);

   // Whether slot 'code' has been written
   function automatic logic slot_written(input logic [CODE_W-1:0] code,
                                         input logic [NUM_SLOTS-1:0] vmask);
      logic hit;
      hit = 1'b0;
      for (int k = 1; k <= NUM_SLOTS; k++) begin
         if (code == CODE_W'(k)) hit = vmask[k-1];
      end
      return hit;
   endfunction

   // Commit permission for a given slot
   function automatic logic commit_allowed(input logic [CODE_W-1:0] code,
                                           input logic [NUM_SLOTS-1:0] vmask);
`ifdef SAVE_OVERWRITE_PROTECT_EN
      return !slot_written(code, vmask);
`else
      return (code != '0) || (vmask != '0) || 1'b1;
`endif
   endfunction

   // Next-state logic and next values of the registered status outputs
   always_comb begin
      state_n    = state;
      cur_code_n = cur_code;
      hold_cnt_n = hold_cnt;
      case (state)
         S_IDLE: begin
            if (save_ok_c) begin
               cur_code_n = save_code_c;
               hold_cnt_n = CNT_W'(1);
               state_n    = (HOLD_CYCLES == 1) ? S_COMMIT : S_QUAL;
            end
         end
         S_QUAL: begin
            if (!save_ok_c) begin
               hold_cnt_n = '0;
               state_n    = S_IDLE;
            end else if (save_code_c == cur_code) begin
               hold_cnt_n = hold_cnt + CNT_W'(1);
               if (hold_cnt_n == CNT_W'(HOLD_CYCLES)) state_n = S_COMMIT;
            end else begin
               // A different valid code restarts qualification
               cur_code_n = save_code_c;
               hold_cnt_n = CNT_W'(1);
            end
         end
         S_COMMIT: begin
            hold_cnt_n = '0;
            state_n    = S_ARMED;
         end
         S_ARMED: begin
            if (!save_ok_c) state_n = S_IDLE;
         end
         default: begin
            hold_cnt_n = '0;
            state_n    = S_IDLE;
         end
      endcase
      // Status pulses are aligned with the COMMIT cycle itself
      save_done_n = (state_n == S_COMMIT) && commit_allowed(cur_code_n, slot_valid);
      busy_n      = (state_n != S_IDLE);
   end

   // FSM state and status registers
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state     <= S_IDLE;
         cur_code  <= '0;
         hold_cnt  <= '0;
         save_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cur_code  <= cur_code_n;
         hold_cnt  <= hold_cnt_n;
         save_done <= save_done_n;
         busy      <= busy_n;
      end
   end

`ifdef SAVE_OVERWRITE_PROTECT_EN
   // Reject pulse for a commit that targets an already written slot
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         save_reject <= 1'b0;
      end else begin
         save_reject <= (state_n == S_COMMIT) && slot_written(cur_code_n, slot_valid);
      end
   end
`else
   assign save_reject = 1'b0;
`endif

   // Load mux reads the pre-write contents, giving read-before-write on a same-slot commit
   logic              load_hit_c;
   logic [DATA_W-1:0] load_data_c;

   always_comb begin
      load_hit_c  = 1'b0;
      load_data_c = '0;
      for (int k = 1; k <= NUM_SLOTS; k++) begin
         if (load_ok_c && (load_code_c == CODE_W'(k)) && slot_valid[k-1]) begin
            load_hit_c  = 1'b1;
            load_data_c = slot_mem[k-1];
         end
      end
   end

   // Slot storage and registered load output
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int k = 0; k < NUM_SLOTS; k++) slot_mem[k] <= '0;
         slot_valid    <= '0;
         sensor_output <= '0;
         load_valid    <= 1'b0;
      end else begin
         if ((state == S_COMMIT) && commit_allowed(cur_code, slot_valid)) begin
            for (int k = 1; k <= NUM_SLOTS; k++) begin
               if (cur_code == CODE_W'(k)) begin
                  slot_mem[k-1]   <= sensor_input_to_save;
                  slot_valid[k-1] <= 1'b1;
               end
            end
         end
         sensor_output <= load_data_c;
         load_valid    <= load_hit_c;
      end
   end

endmodule

// File: tb/tb_save_slot_store.sv
// tb_save_slot_store: directed scenarios plus randomized traffic against a run-length
// reference model of the save/load behaviour.
module tb_save_slot_store;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned NUM_SLOTS = 3;
   localparam int unsigned HOLD      = 4;
`ifdef SAVE_OVERWRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic                 iVGA_CLK = 1'b0;
   logic                 iRST_n;
   logic [DATA_W-1:0]    save_signal;
   logic [DATA_W-1:0]    sensor_input_to_save;
   logic [DATA_W-1:0]    load_signal;
   logic [DATA_W-1:0]    sensor_output;
   logic                 load_valid;
   logic [NUM_SLOTS-1:0] slot_valid;
   logic                 save_done;
   logic                 busy;
   logic                 save_reject;

   save_slot_store #(.DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .HOLD_CYCLES(HOLD)) dut (
      .iVGA_CLK             (iVGA_CLK),
      .iRST_n               (iRST_n),
      .save_signal          (save_signal),
      .sensor_input_to_save (sensor_input_to_save),
      .load_signal          (load_signal),
      .sensor_output        (sensor_output),
      .load_valid           (load_valid),
      .slot_valid           (slot_valid),
      .save_done            (save_done),
      .busy                 (busy),
      .save_reject          (save_reject)
   );

   always #5 iVGA_CLK = ~iVGA_CLK;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: per-slot memory plus the length of the current stable request run
   logic [DATA_W-1:0] m_mem [1:NUM_SLOTS];
   bit                m_val [1:NUM_SLOTS];
   logic [DATA_W-1:0] run_code;
   int                run_len;
   bit                armed, pending;
   logic [DATA_W-1:0] pend_code;
   logic [DATA_W-1:0] exp_out;
   bit                exp_lv, exp_done, exp_rej, exp_busy;

   function automatic bit code_ok(input logic [DATA_W-1:0] c);
      return (c >= 1) && (c <= NUM_SLOTS);
   endfunction

   function automatic logic [NUM_SLOTS-1:0] exp_slot_valid();
      logic [NUM_SLOTS-1:0] v;
      for (int k = 1; k <= NUM_SLOTS; k++) v[k-1] = m_val[k];
      return v;
   endfunction

   task automatic model_clear();
      for (int k = 1; k <= NUM_SLOTS; k++) begin
         m_mem[k] = '0;
         m_val[k] = 1'b0;
      end
      run_code = '0; run_len = 0; armed = 0; pending = 0; pend_code = '0;
      exp_out = '0; exp_lv = 0; exp_done = 0; exp_rej = 0; exp_busy = 0;
   endtask

   // One clock: apply inputs, advance the model with what the edge sampled, settle
   task automatic step(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] d,
                       input logic [DATA_W-1:0] l);
      save_signal          = s;
      sensor_input_to_save = d;
      load_signal          = l;
      @(posedge iVGA_CLK);
      if (code_ok(l) && m_val[l]) begin
         exp_out = m_mem[l]; exp_lv = 1;
      end else begin
         exp_out = '0; exp_lv = 0;
      end
      exp_done = 0;
      exp_rej  = 0;
      if (pending) begin
         // The commit cycle ignores the request code entirely
         if (!(PROT && m_val[pend_code])) begin
            m_mem[pend_code] = d;
            m_val[pend_code] = 1;
         end
         pending = 0;
         armed   = 1;
         run_len = 0;
      end else if (!code_ok(s)) begin
         run_len = 0;
         armed   = 0;
      end else if (!armed) begin
         if (run_len > 0 && s == run_code) run_len++;
         else begin
            run_code = s;
            run_len  = 1;
         end
         if (run_len == HOLD) begin
            pending   = 1;
            pend_code = run_code;
            run_len   = 0;
            exp_rej   = PROT && m_val[run_code];
            exp_done  = !exp_rej;
         end
      end
      exp_busy = (run_len > 0) || pending || armed;
      #1;
   endtask

   task automatic test_reset();
      iRST_n = 1'b0;
      save_signal = '0; sensor_input_to_save = '0; load_signal = '0;
      model_clear();
      #3;
      n_vec++;
      if ({sensor_output, load_valid, slot_valid, save_done, busy, save_reject} !== '0)
         begin n_err++; $display("FAIL reset_outputs: got out=%h lv=%b sv=%b done=%b busy=%b rej=%b, expected all 0",
                  sensor_output, load_valid, slot_valid, save_done, busy, save_reject); end
      @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      step(32'd0, 32'd0, 32'd1);
      n_vec++;
      if (sensor_output !== 32'd0 || load_valid !== 1'b0 || slot_valid !== 3'b000)
         begin n_err++; $display("FAIL reset_load_empty: got out=%h lv=%b sv=%b, expected 0 0 000",
                  sensor_output, load_valid, slot_valid); end
   endtask

   task automatic test_basic_save();
      for (int i = 1; i <= 10; i++) begin
         step(32'd1, 32'h0000_0041, 32'd0);
         n_vec++;
         if (save_done !== (i == HOLD) || busy !== 1'b1)
            begin n_err++; $display("FAIL basic_save_cycle%0d: got done=%b busy=%b, expected done=%b busy=1",
                     i, save_done, busy, (i == HOLD)); end
      end
      step(32'd0, 32'h0, 32'd0);
      n_vec++;
      if (busy !== 1'b0 || slot_valid !== 3'b001)
         begin n_err++; $display("FAIL basic_save_release: got busy=%b sv=%b, expected 0 001", busy, slot_valid); end
   endtask

   task automatic test_load();
      step(32'd0, 32'h0, 32'd1);
      n_vec++;
      if (sensor_output !== 32'h41 || load_valid !== 1'b1)
         begin n_err++; $display("FAIL load_slot1: got %h lv=%b, expected 00000041 lv=1", sensor_output, load_valid); end
      step(32'd0, 32'h0, 32'd5);
      n_vec++;
      if (sensor_output !== 32'h0 || load_valid !== 1'b0)
         begin n_err++; $display("FAIL load_code5: got %h lv=%b, expected 0 lv=0", sensor_output, load_valid); end
      step(32'd0, 32'h0, 32'h0001_0001);
      n_vec++;
      if (sensor_output !== 32'h0 || load_valid !== 1'b0)
         begin n_err++; $display("FAIL load_wide_code: got %h lv=%b, expected 0 lv=0", sensor_output, load_valid); end
   endtask

   task automatic test_abort_switch();
      for (int i = 1; i <= 3; i++) step(32'd2, 32'h22, 32'd0);
      step(32'd0, 32'h22, 32'd0);
      n_vec++;
      if (slot_valid !== 3'b001 || busy !== 1'b0)
         begin n_err++; $display("FAIL abort_no_write: got sv=%b busy=%b, expected 001 0", slot_valid, busy); end
      for (int i = 1; i <= 2; i++) step(32'd2, 32'h22, 32'd0);
      for (int j = 1; j <= 5; j++) begin
         step(32'd3, 32'h0000_0033, 32'd0);
         n_vec++;
         if (save_done !== (j == HOLD))
            begin n_err++; $display("FAIL switch_done_cycle%0d: got %b expected %b", j, save_done, (j == HOLD)); end
      end
      n_vec++;
      if (slot_valid !== 3'b101)
         begin n_err++; $display("FAIL switch_slot_valid: got %b expected 101", slot_valid); end
      step(32'd0, 32'h0, 32'd3);
      n_vec++;
      if (sensor_output !== 32'h33 || load_valid !== 1'b1)
         begin n_err++; $display("FAIL switch_load3: got %h lv=%b, expected 00000033 lv=1", sensor_output, load_valid); end
   endtask

   task automatic test_read_before_write();
      for (int i = 1; i <= HOLD + 1; i++) step(32'd2, 32'hAA, 32'd0);
      step(32'd0, 32'h0, 32'd2);
      n_vec++;
      if (sensor_output !== 32'hAA || load_valid !== 1'b1)
         begin n_err++; $display("FAIL rbw_initial: got %h lv=%b, expected 000000aa lv=1", sensor_output, load_valid); end
      for (int j = 1; j <= HOLD + 2; j++) begin
         step(32'd2, 32'hBB, 32'd2);
         n_vec++;
         if (j <= HOLD + 1) begin
            if (sensor_output !== 32'hAA)
               begin n_err++; $display("FAIL rbw_old_cycle%0d: got %h expected 000000aa", j, sensor_output); end
         end else begin
            if (sensor_output !== (PROT ? 32'hAA : 32'hBB))
               begin n_err++; $display("FAIL rbw_new: got %h expected %h", sensor_output, PROT ? 32'hAA : 32'hBB); end
         end
         if (j == HOLD) begin
            n_vec++;
            if (save_done !== !PROT || save_reject !== PROT)
               begin n_err++; $display("FAIL rbw_pulses: got done=%b rej=%b, expected %b %b",
                        save_done, save_reject, !PROT, PROT); end
         end
      end
      step(32'd0, 32'h0, 32'd0);
   endtask

   task automatic test_reset_mid_qual();
      step(32'd1, 32'h77, 32'd1);
      step(32'd1, 32'h77, 32'd1);
      #2;
      iRST_n = 1'b0;
      #1;
      model_clear();
      n_vec++;
      if ({sensor_output, load_valid, slot_valid, save_done, busy, save_reject} !== '0)
         begin n_err++; $display("FAIL reset_mid_qual: got out=%h lv=%b sv=%b done=%b busy=%b rej=%b, expected all 0",
                  sensor_output, load_valid, slot_valid, save_done, busy, save_reject); end
      @(posedge iVGA_CLK);
      #3;
      iRST_n = 1'b1;
      for (int j = 1; j <= HOLD + 1; j++) begin
         step(32'd1, 32'h0000_0099, 32'd0);
         n_vec++;
         if (save_done !== (j == HOLD) || slot_valid !== ((j > HOLD) ? 3'b001 : 3'b000))
            begin n_err++; $display("FAIL post_reset_cycle%0d: got done=%b sv=%b, expected done=%b sv=%b",
                     j, save_done, slot_valid, (j == HOLD), (j > HOLD) ? 3'b001 : 3'b000); end
      end
      step(32'd0, 32'h0, 32'd1);
      n_vec++;
      if (sensor_output !== 32'h99)
         begin n_err++; $display("FAIL post_reset_load: got %h expected 00000099", sensor_output); end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] s, l;
      int hold_left;
      hold_left = 0;
      s = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold_left == 0) begin
            case ($urandom_range(0, 6))
               0, 1:    s = 32'd0;
               6:       s = 32'hFFFF_FFF0;
               default: s = 32'($urandom_range(1, NUM_SLOTS + 1));
            endcase
            hold_left = $urandom_range(1, 8);
         end
         hold_left--;
         l = 32'($urandom_range(0, NUM_SLOTS + 1));
         step(s, $urandom, l);
         n_vec++;
         if ({sensor_output, load_valid, slot_valid, save_done, save_reject, busy} !==
             {exp_out, exp_lv, exp_slot_valid(), exp_done, exp_rej, exp_busy})
            begin n_err++; $display("FAIL random_cycle%0d: got out=%h lv=%b sv=%b done=%b rej=%b busy=%b, expected out=%h lv=%b sv=%b done=%b rej=%b busy=%b",
                     cyc, sensor_output, load_valid, slot_valid, save_done, save_reject, busy,
                     exp_out, exp_lv, exp_slot_valid(), exp_done, exp_rej, exp_busy); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_save();
      test_load();
      test_abort_switch();
      test_read_before_write();
      test_reset_mid_qual();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, got stuck, expected completion");
      $fatal(1);
   end

endmodule
